// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite channel bundle between the register master and axi_lite_reg_slave.
interface axi_lite_reg_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave with four 32-bit control/status registers and per-register write pulses.
// Optional AXI_LITE_SLVERR_EN: addresses above 0xF are rejected with SLVERR instead of aliasing.
module axi_lite_reg_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      S_AXI_ACLK,
   input  logic                      S_AXI_ARESET,
   axi_lite_reg_slave_if.slave       s_axi,
   output logic [4*DATA_WIDTH-1:0]   regs_o,
   output logic [3:0]                wr_pulse_o
);

   function automatic logic [DATA_WIDTH-1:0] apply_strobe(
      input logic [DATA_WIDTH-1:0] old_v,
      input logic [DATA_WIDTH-1:0] new_v,
      input logic [3:0]            strb
   );
      logic [DATA_WIDTH-1:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   logic [3:0][DATA_WIDTH-1:0] regs_r;
   logic [3:0]                 wr_pulse_r;

   logic                  aw_full_r;
   logic [1:0]            aw_idx_r;
   logic                  aw_oor_r;
   logic                  w_full_r;
   logic [DATA_WIDTH-1:0] w_data_r;
   logic [3:0]            w_strb_r;
   logic                  bvalid_r;
   logic [1:0]            bresp_r;
   logic                  awready_r;
   logic                  wready_r;

   logic                  rvalid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;
   logic                  arready_r;

   logic aw_hs_s;
   logic w_hs_s;
   logic ar_hs_s;
   logic commit_s;
   logic aw_full_nxt_s;
   logic w_full_nxt_s;
   logic bvalid_nxt_s;
   logic rvalid_nxt_s;
   logic aw_oor_s;
   logic ar_oor_s;
   logic unused_s;

`ifdef AXI_LITE_SLVERR_EN
   assign aw_oor_s = |s_axi.awaddr[ADDR_WIDTH-1:4];
   assign ar_oor_s = |s_axi.araddr[ADDR_WIDTH-1:4];
`else
   assign aw_oor_s = 1'b0;
   assign ar_oor_s = 1'b0;
`endif

   assign unused_s = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

   // Handshake decode and next-state for buffer occupancy and response valids.
   always_comb begin
      aw_hs_s  = s_axi.awvalid && awready_r;
      w_hs_s   = s_axi.wvalid && wready_r;
      ar_hs_s  = s_axi.arvalid && arready_r;
      // A handshake cannot coincide with commit: READY is low whenever its buffer is full.
      commit_s = aw_full_r && w_full_r && !bvalid_r;
      if (commit_s) begin
         aw_full_nxt_s = 1'b0;
         w_full_nxt_s  = 1'b0;
      end else begin
         aw_full_nxt_s = aw_full_r || aw_hs_s;
         w_full_nxt_s  = w_full_r || w_hs_s;
      end
      if (commit_s) begin
         bvalid_nxt_s = 1'b1;
      end else if (s_axi.bready) begin
         bvalid_nxt_s = 1'b0;
      end else begin
         bvalid_nxt_s = bvalid_r;
      end
      if (ar_hs_s) begin
         rvalid_nxt_s = 1'b1;
      end else if (s_axi.rready) begin
         rvalid_nxt_s = 1'b0;
      end else begin
         rvalid_nxt_s = rvalid_r;
      end
   end

   // Write address/data holding buffers, B channel and registered write READYs.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         aw_full_r <= 1'b0;
         aw_idx_r  <= 2'b00;
         aw_oor_r  <= 1'b0;
         w_full_r  <= 1'b0;
         w_data_r  <= {DATA_WIDTH{1'b0}};
         w_strb_r  <= 4'b0000;
         bvalid_r  <= 1'b0;
         bresp_r   <= 2'b00;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
      end else begin
         aw_full_r <= aw_full_nxt_s;
         w_full_r  <= w_full_nxt_s;
         if (aw_hs_s) begin
            aw_idx_r <= s_axi.awaddr[3:2];
            aw_oor_r <= aw_oor_s;
         end
         if (w_hs_s) begin
            w_data_r <= s_axi.wdata;
            w_strb_r <= s_axi.wstrb;
         end
         bvalid_r <= bvalid_nxt_s;
         if (commit_s) begin
            bresp_r <= aw_oor_r ? 2'b10 : 2'b00;
         end
         awready_r <= !aw_full_nxt_s && !bvalid_nxt_s;
         wready_r  <= !w_full_nxt_s && !bvalid_nxt_s;
      end
   end

   // Register file update on commit, with a one-cycle strobe to the core.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         regs_r     <= {(4*DATA_WIDTH){1'b0}};
         wr_pulse_r <= 4'b0000;
      end else begin
         wr_pulse_r <= 4'b0000;
         if (commit_s && !aw_oor_r) begin
            regs_r[aw_idx_r] <= apply_strobe(regs_r[aw_idx_r], w_data_r, w_strb_r);
            wr_pulse_r       <= 4'b0001 << aw_idx_r;
         end
      end
   end

   // Read channel; sampling regs_r here yields the pre-write value on a same-edge commit.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rvalid_r  <= 1'b0;
         rdata_r   <= {DATA_WIDTH{1'b0}};
         rresp_r   <= 2'b00;
         arready_r <= 1'b0;
      end else begin
         rvalid_r  <= rvalid_nxt_s;
         arready_r <= !rvalid_nxt_s;
         if (ar_hs_s) begin
            rdata_r <= ar_oor_s ? {DATA_WIDTH{1'b0}} : regs_r[s_axi.araddr[3:2]];
            rresp_r <= ar_oor_s ? 2'b10 : 2'b00;
         end
      end
   end

   assign s_axi.awready = awready_r;
   assign s_axi.wready  = wready_r;
   assign s_axi.bvalid  = bvalid_r;
   assign s_axi.bresp   = bresp_r;
   assign s_axi.arready = arready_r;
   assign s_axi.rvalid  = rvalid_r;
   assign s_axi.rdata   = rdata_r;
   assign s_axi.rresp   = rresp_r;
   assign regs_o        = regs_r;
   assign wr_pulse_o    = wr_pulse_r;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: register write/read, strobes, ordering, collision, reset.
module tb_axi_lite_reg_slave;

   logic         tb_ACLK = 1'b0;
   logic         tb_rst;
   logic [127:0] regs;
   logic [3:0]   wr_pulse;
   int           checks = 0;
   int           errors = 0;

   axi_lite_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .S_AXI_ACLK   (tb_ACLK),
      .S_AXI_ARESET (tb_rst),
      .s_axi        (bus),
      .regs_o       (regs),
      .wr_pulse_o   (wr_pulse)
   );

   always #5 tb_ACLK = ~tb_ACLK;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      logic aw_go;
      logic w_go;
      int   n;
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      n = 0;
      while ((bus.awvalid || bus.wvalid) && n < 20) begin
         aw_go = bus.awvalid && bus.awready;
         w_go  = bus.wvalid && bus.wready;
         @(posedge tb_ACLK); #1;
         if (aw_go) bus.awvalid = 1'b0;
         if (w_go)  bus.wvalid  = 1'b0;
         n++;
      end
      chk("wr_accept", {bus.awvalid, bus.wvalid}, 2'b00);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      n = 0;
      while (!bus.bvalid && n < 20) begin
         @(posedge tb_ACLK); #1;
         n++;
      end
      chk("wr_bvalid", bus.bvalid, 1'b1);
      resp = bus.bresp;
      bus.bready = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      logic ar_go;
      int   n;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      n = 0;
      while (bus.arvalid && n < 20) begin
         ar_go = bus.arready;
         @(posedge tb_ACLK); #1;
         if (ar_go) bus.arvalid = 1'b0;
         n++;
      end
      chk("rd_accept", bus.arvalid, 1'b0);
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 20) begin
         @(posedge tb_ACLK); #1;
         n++;
      end
      chk("rd_rvalid", bus.rvalid, 1'b1);
      data = bus.rdata;
      resp = bus.rresp;
      bus.rready = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.rready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rr;
      logic [1:0]  br;

      tb_rst      = 1'b1;
      bus.awaddr  = 32'h0;
      bus.awprot  = 3'b000;
      bus.awvalid = 1'b0;
      bus.wdata   = 32'h0;
      bus.wstrb   = 4'h0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = 32'h0;
      bus.arprot  = 3'b000;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;

      // Reset values
      repeat (3) @(posedge tb_ACLK);
      #1;
      chk("rst_regs", regs, 128'h0);
      chk("rst_pulse", wr_pulse, 4'h0);
      chk("rst_b", {bus.bvalid, bus.bresp}, 3'b000);
      chk("rst_r", {bus.rvalid, bus.rresp, bus.rdata}, 35'h0);
      chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
      tb_rst = 1'b0;
      @(posedge tb_ACLK); #1;
      chk("post_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);

      // Four write/read pairs
      axi_write(32'h0, 32'h0101FFFF, 4'hF, br); chk("w0_bresp", br, 2'b00);
      axi_read(32'h0, rd, rr); chk("r0_data", rd, 32'h0101FFFF); chk("r0_rresp", rr, 2'b00);
      axi_write(32'h4, 32'hABCD0001, 4'hF, br); chk("w1_bresp", br, 2'b00);
      axi_read(32'h4, rd, rr); chk("r1_data", rd, 32'hABCD0001); chk("r1_rresp", rr, 2'b00);
      axi_write(32'h8, 32'hDEAD0011, 4'hF, br); chk("w2_bresp", br, 2'b00);
      axi_read(32'h8, rd, rr); chk("r2_data", rd, 32'hDEAD0011); chk("r2_rresp", rr, 2'b00);
      axi_write(32'hC, 32'hBEEF0011, 4'hF, br); chk("w3_bresp", br, 2'b00);
      axi_read(32'hC, rd, rr); chk("r3_data", rd, 32'hBEEF0011); chk("r3_rresp", rr, 2'b00);
      chk("regs_all", regs, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});

      // Byte strobes with cycle-exact latency and pulse width
      bus.awaddr = 32'h4; bus.wdata = 32'h12345678; bus.wstrb = 4'b0101;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      chk("strb_hs_pulse", wr_pulse, 4'b0000);
      chk("strb_hs_b", bus.bvalid, 1'b0);
      chk("strb_hs_reg1", regs[63:32], 32'hABCD0001);
      @(posedge tb_ACLK); #1;
      chk("strb_commit_pulse", wr_pulse, 4'b0010);
      chk("strb_commit_b", bus.bvalid, 1'b1);
      chk("strb_commit_reg1", regs[63:32], 32'hAB340078);
      @(posedge tb_ACLK); #1;
      chk("strb_pulse_end", wr_pulse, 4'b0000);
      bus.bready = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.bready = 1'b0;
      chk("strb_b_done", bus.bvalid, 1'b0);
      chk("b2b_ready", {bus.awready, bus.wready}, 2'b11);
      axi_read(32'h4, rd, rr); chk("strb_read", rd, 32'hAB340078);

      // W three cycles ahead of AW, then B backpressure
      bus.wdata = 32'h11223344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.wvalid = 1'b0;
      chk("ord_w_taken", {bus.wready, bus.awready}, 2'b01);
      @(posedge tb_ACLK); #1;
      @(posedge tb_ACLK); #1;
      chk("ord_aw_ready", {bus.awready, bus.bvalid}, 2'b10);
      bus.awaddr = 32'hC; bus.awvalid = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.awvalid = 1'b0;
      chk("ord_aw_hs", {bus.bvalid, regs[127:96]}, {1'b0, 32'hBEEF0011});
      @(posedge tb_ACLK); #1;
      chk("ord_commit", {bus.bvalid, regs[127:96]}, {1'b1, 32'h11223344});
      chk("ord_pulse", wr_pulse, 4'b1000);
      for (int i = 0; i < 5; i++) begin
         @(posedge tb_ACLK); #1;
         chk("bp_hold", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
      end
      chk("bp_bresp", bus.bresp, 2'b00);
      bus.bready = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.bready = 1'b0;
      chk("bp_release", bus.bvalid, 1'b0);

      // Read accepted on the commit edge of a write to the same register
      bus.awaddr = 32'h8; bus.wdata = 32'h0; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.araddr = 32'h8; bus.arvalid = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.arvalid = 1'b0;
      chk("coll_rvalid", {bus.rvalid, bus.bvalid}, 2'b11);
      chk("coll_rdata", bus.rdata, 32'hDEAD0011);
      chk("coll_reg2", regs[95:64], 32'h0);
      bus.rready = 1'b1; bus.bready = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.rready = 1'b0; bus.bready = 1'b0;
      chk("coll_done", {bus.rvalid, bus.bvalid}, 2'b00);
      axi_read(32'h8, rd, rr); chk("coll_reread", rd, 32'h0);

      // Address above the register window
      axi_write(32'h10, 32'h00000055, 4'hF, br);
      axi_read(32'h10, rd, rr);
`ifdef AXI_LITE_SLVERR_EN
      chk("oor_bresp", br, 2'b10);
      chk("oor_reg0", regs[31:0], 32'h0101FFFF);
      chk("oor_read", {rr, rd}, {2'b10, 32'h0});
`else
      chk("oor_bresp", br, 2'b00);
      chk("oor_reg0", regs[31:0], 32'h00000055);
      chk("oor_read", {rr, rd}, {2'b00, 32'h00000055});
`endif

      // Reset while both B and R are pending
      bus.awaddr = 32'h4; bus.wdata = 32'h77; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      bus.araddr = 32'h0; bus.arvalid = 1'b1;
      @(posedge tb_ACLK); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      @(posedge tb_ACLK); #1;
      chk("mid_pending", {bus.bvalid, bus.rvalid}, 2'b11);
      #2;
      tb_rst = 1'b1;
      #1;
      chk("mid_rst_regs", regs, 128'h0);
      chk("mid_rst_b", {bus.bvalid, bus.bresp, wr_pulse}, 7'h0);
      chk("mid_rst_r", {bus.rvalid, bus.rresp, bus.rdata}, 35'h0);
      chk("mid_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
      @(posedge tb_ACLK); #1;
      tb_rst = 1'b0;
      bus.bready = 1'b1; bus.rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge tb_ACLK); #1;
         chk("mid_no_resp", {bus.bvalid, bus.rvalid}, 2'b00);
      end
      chk("mid_after_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
      chk("mid_after_regs", regs, 128'h0);
      bus.bready = 1'b0; bus.rready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
